store_narrow: RTL and testbench
===============================

STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of in_addr/out_addr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  store request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data  input  32  register value to store (low bytes significant).
REQ-007 SHALL have port in_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port in_size  input  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port in_signed  input  1  value is signed; used only by the range check.
REQ-010 SHALL have port out_valid  output  1  memory write beat present.
REQ-011 SHALL have port out_ready  input  1  beat consumed when out_valid && out_ready.
REQ-012 SHALL have port out_addr  output  ADDR_W  word-aligned address, bits [1:0] always 0.
REQ-013 SHALL have port out_data  output  32  lane-positioned write data.
REQ-014 SHALL have port out_be  output  4  byte enables, bit k = lane k.
REQ-015 SHALL have port out_last  output  1  final beat of the request.
REQ-016 SHALL have port err_size  output  1  one-cycle pulse on acceptance of in_size==3.
REQ-017 SHALL have port err_range  output  1  range violation, qualified by out_valid.

Function
REQ-018 SHALL narrow in_data to N = 1/2/4 bytes and map byte k, little-endian, to lane (in_addr[1:0]+k) mod 4.
REQ-019 SHALL emit one beat when in_addr[1:0]+N <= 4; otherwise two beats: first at word(in_addr), second at word(in_addr)+4 carrying the wrapped bytes.
REQ-020 SHALL set out_data lanes with out_be==0 to 0.
REQ-021 SHALL implement states IDLE, BEAT1, BEAT2: IDLE->BEAT1 on accept; BEAT1->IDLE, or ->BEAT1 on a simultaneous accept, on handshake when single-beat; BEAT1->BEAT2 on handshake when split; BEAT2->IDLE, or ->BEAT1 on a simultaneous accept, on handshake.
REQ-022 SHALL present the first beat registered, exactly one cycle after acceptance.
REQ-023 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_last), giving one aligned request per cycle under continuous out_ready.
REQ-024 SHALL hold out_addr, out_data, out_be, out_last and err_range stable while out_valid && !out_ready.
REQ-025 SHALL compute out_addr wrap-around modulo 2^ADDR_W on the second beat (last word -> address 0).
REQ-026 SHALL accept a request with in_size==3, pulse err_size the following cycle, produce no beat and stay in or return to IDLE.

Reset
REQ-027 SHALL, while rst_n==0, force state IDLE, out_valid 0, out_addr 0, out_data 0, out_be 0, out_last 0, err_size 0 and err_range 0, aborting any in-flight request with no further beats.
REQ-028 SHALL drive in_ready 1 on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro STORE_NARROW_RANGE_CHECK_EN defined, assert err_range on the first beat of a byte or half request whose in_data is not the sign-extension (in_signed=1) or zero-extension (in_signed=0) of its low 8/16 bits; data is still stored truncated.
REQ-030 SHALL, without STORE_NARROW_RANGE_CHECK_EN, tie err_range to 0 and ignore in_signed; all other behaviour is identical.

Structure
REQ-031 SHALL place size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD and the state enum in shared package store_narrow_pkg.
REQ-032 SHALL use one combinational sub-module lane_rotate producing a 64-bit data and 8-bit enable image from data, size and offset; the low half is beat 1 and the high half is beat 2.

Verification
REQ-033 SHALL cover: word 0xDEADBEEF @0x100, out_ready=1 -> one beat, addr 0x100, be 1111, data 0xDEADBEEF, last 1, one cycle after accept.
REQ-034 SHALL cover: half 0x0000ABCD @0x203 -> beat1 addr 0x200 be 1000 data 0xCD000000 last 0; beat2 addr 0x204 be 0001 data 0x000000AB last 1.
REQ-035 SHALL cover: byte 0x77 @0x7 with out_ready held 0 for 3 cycles -> outputs stable, in_ready 0, then beat addr 0x4 be 1000 data 0x77000000.
REQ-036 SHALL cover: with STORE_NARROW_RANGE_CHECK_EN, byte in_data 0xFFFFFF80 signed -> err_range 0; in_data 0x00000180 signed -> err_range 1, data lane value 0x80.
REQ-037 SHALL cover: word @0xFFFFFFFE -> beat2 addr 0x00000000 be 0011; rst_n pulsed low between beats -> no beat2 and out_valid 0.
REQ-038 SHALL cover: in_size 3 accepted -> err_size single pulse, no out_valid; next aligned request accepted back-to-back.

Source files
------------

// File: rtl/store_narrow_pkg.sv
// store_narrow_pkg: shared definitions for the store_narrow slice.
//   - size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   - state_t : store sequencer states (IDLE, BEAT1, BEAT2)
//   - range_ok(): true when a byte/half store value fits its narrowed width
package store_narrow_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2
   } state_t;

   // A byte/half value fits when the discarded upper bits are a pure
   // sign-extension (signed) or zero-extension (unsigned) of the kept bits.
   // Words and reserved sizes always fit.
   function automatic logic range_ok(input logic [31:0] d,
                                     input logic [1:0]  sz,
                                     input logic        sgn);
      logic r;
      r = 1'b1;
      case (sz)
         SZ_BYTE: r = (d[31:8]  == (sgn ? {24{d[7]}}  : 24'h0));
         SZ_HALF: r = (d[31:16] == (sgn ? {16{d[15]}} : 16'h0));
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/store_narrow_lane_rotate.sv
// lane_rotate: combinational lane placement for a narrow store.
//   data     [31:0] register value (low bytes significant)
//   size     [1:0]  SZ_BYTE / SZ_HALF / SZ_WORD (SZ_RSVD -> empty image)
//   offset   [1:0]  byte offset within the first word
//   img_data [63:0] two-word data image; [31:0] beat 1, [63:32] beat 2
//   img_be   [7:0]  two-word enable image; [3:0] beat 1, [7:4] beat 2
// Unused bytes are zero before shifting, so disabled lanes carry 0.
module lane_rotate
   import store_narrow_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   output logic [63:0] img_data,
   output logic [7:0]  img_be
);

   logic [31:0] narrowed;
   logic [3:0]  be_base;

   always_comb begin
      narrowed = 32'h0;
      be_base  = 4'b0000;
      case (size)
         SZ_BYTE: begin narrowed = {24'h0, data[7:0]};  be_base = 4'b0001; end
         SZ_HALF: begin narrowed = {16'h0, data[15:0]}; be_base = 4'b0011; end
         SZ_WORD: begin narrowed = data;                be_base = 4'b1111; end
         default: begin narrowed = 32'h0;               be_base = 4'b0000; end
      endcase
      // Shifting into a 64-bit window turns lane wrap into a second word.
      img_data = {32'h0, narrowed} << {offset, 3'b000};
      img_be   = {4'h0, be_base} << offset;
   end

endmodule

// File: rtl/store_narrow.sv
// store_narrow: splits a byte/half/word store into one or two word-aligned
// memory write beats with lane-positioned data and byte enables.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake (accept = in_valid && in_ready)
//   in_data, in_addr, in_size  store value, byte address, size encoding
//   in_signed                  signedness, only used by the range check
//   out_valid/out_ready        beat handshake (consumed = out_valid && out_ready)
//   out_addr/out_data/out_be   word address, lane data, byte enables
//   out_last                   final beat of the request
//   err_size                   one-cycle pulse after accepting in_size==3
//   err_range                  range violation on the first beat (out_valid qualified)
//   dbg_state                  current sequencer state
// Handshake: both interfaces transfer on a cycle where valid && ready at the
// rising edge; outputs stay stable while out_valid && !out_ready.
// Build option: define STORE_NARROW_RANGE_CHECK_EN to enable err_range;
// otherwise err_range is tied low and in_signed is ignored.
module store_narrow
   import store_narrow_pkg::*;
#(
   parameter int ADDR_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_data,
   output logic [3:0]        out_be,
   output logic              out_last,
   output logic              err_size,
   output logic              err_range,
   output logic [1:0]        dbg_state
);

   state_t      state;
   logic [31:0] b2_data;
   logic [3:0]  b2_be;
   logic [63:0] img_data;
   logic [7:0]  img_be;
   logic        accept;
   logic        hs;
   logic        range_err;

   lane_rotate u_rot (
      .data     (in_data),
      .size     (in_size),
      .offset   (in_addr[1:0]),
      .img_data (img_data),
      .img_be   (img_be)
   );

`ifdef STORE_NARROW_RANGE_CHECK_EN
   assign range_err = !range_ok(in_data, in_size, in_signed);
`else
   logic unused_signed;
   assign unused_signed = in_signed;
   assign range_err     = 1'b0;
`endif

   assign out_valid = (state != IDLE);
   assign hs        = out_valid && out_ready;
   // A new request may enter in the same cycle the final beat leaves.
   assign in_ready  = (state == IDLE) || (hs && out_last);
   assign accept    = in_valid && in_ready;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_addr  <= '0;
         out_data  <= 32'h0;
         out_be    <= 4'h0;
         out_last  <= 1'b0;
         err_size  <= 1'b0;
         err_range <= 1'b0;
         b2_data   <= 32'h0;
         b2_be     <= 4'h0;
      end else begin
         err_size <= 1'b0;
         if (accept) begin
            if (in_size == SZ_RSVD) begin
               state    <= IDLE;
               err_size <= 1'b1;
            end else begin
               state     <= BEAT1;
               out_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
               out_data  <= img_data[31:0];
               out_be    <= img_be[3:0];
               out_last  <= (img_be[7:4] == 4'h0);
               err_range <= range_err;
               b2_data   <= img_data[63:32];
               b2_be     <= img_be[7:4];
            end
         end else if (hs) begin
            if (out_last) begin
               state <= IDLE;
            end else begin
               state     <= BEAT2;
               // Natural ADDR_W overflow wraps the last word to address 0.
               out_addr  <= out_addr + ADDR_W'(4);
               out_data  <= b2_data;
               out_be    <= b2_be;
               out_last  <= 1'b1;
               err_range <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_store_narrow.sv
module tb_store_narrow;

`ifdef STORE_NARROW_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // beat image: {addr[31:0], data[31:0], be[3:0], last, err_range}
  localparam int BW = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [31:0] in_addr = 32'h0;
  logic [1:0]  in_size = 2'd0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_last;
  logic        err_size;
  logic        err_range;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;
  logic [BW-1:0] exp_q[$];

  store_narrow #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_be(out_be), .out_last(out_last),
    .err_size(err_size), .err_range(err_range), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic accept_req(input logic [31:0] d, input logic [31:0] a,
                            input logic [1:0] sz, input logic sg);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; in_addr = a; in_size = sz; in_signed = sg;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  // Places each of the N bytes at absolute byte position offset+k; positions
  // 4..7 belong to the following word.
  task automatic model_push(input logic [31:0] d, input logic [31:0] a,
                            input logic [1:0] sz, input logic sg);
    int n, off, pos, sd;
    logic [31:0] d0, d1, base;
    logic [3:0]  be0, be1;
    logic [7:0]  bval;
    logic        rng;
    if (sz == 2'd3) return;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    base = a - 32'(off);
    d0 = 0; d1 = 0; be0 = 0; be1 = 0;
    for (int k = 0; k < n; k++) begin
      bval = 8'((d >> (8 * k)) & 32'hFF);
      pos  = off + k;
      if (pos < 4) begin d0 = d0 | (32'(bval) << (8 * pos)); be0[pos] = 1'b1; end
      else begin d1 = d1 | (32'(bval) << (8 * (pos - 4))); be1[pos - 4] = 1'b1; end
    end
    sd  = $signed(d);
    rng = 1'b0;
    if (RANGE_EN) begin
      if (n == 1) rng = sg ? !(sd >= -128 && sd <= 127) : (d > 32'd255);
      if (n == 2) rng = sg ? !(sd >= -32768 && sd <= 32767) : (d > 32'd65535);
    end
    exp_q.push_back({base, d0, be0, (off + n <= 4), rng});
    if (off + n > 4) exp_q.push_back({base + 32'd4, d1, be1, 1'b1, 1'b0});
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_data, out_be, out_last, err_size, err_range, dbg_state} !== 73'h0) begin
      $display("FAIL reset_outputs: got v=%b a=%h d=%h be=%b l=%b es=%b er=%b st=%0d required all 0",
               out_valid, out_addr, out_data, out_be, out_last, err_size, err_range, dbg_state);
    end else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else passed++;
    step();
  endtask

  task automatic test_word_aligned;
    out_ready = 1'b1;
    accept_req(32'hDEADBEEF, 32'h100, 2'd2, 1'b0);
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_be, out_data, out_last} !== {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1})
      $display("FAIL word_beat: got v=%b a=%h be=%b d=%h l=%b required v=1 a=00000100 be=1111 d=deadbeef l=1",
               out_valid, out_addr, out_be, out_data, out_last);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL word_done: out_valid got %b required 0", out_valid);
    else passed++;
    step();
  endtask

  task automatic test_half_split;
    out_ready = 1'b1;
    accept_req(32'h0000ABCD, 32'h203, 2'd1, 1'b0);
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_be, out_data, out_last} !== {1'b1, 32'h200, 4'b1000, 32'hCD000000, 1'b0})
      $display("FAIL half_beat1: got v=%b a=%h be=%b d=%h l=%b required v=1 a=00000200 be=1000 d=cd000000 l=0",
               out_valid, out_addr, out_be, out_data, out_last);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_be, out_data, out_last} !== {1'b1, 32'h204, 4'b0001, 32'h000000AB, 1'b1})
      $display("FAIL half_beat2: got v=%b a=%h be=%b d=%h l=%b required v=1 a=00000204 be=0001 d=000000ab l=1",
               out_valid, out_addr, out_be, out_data, out_last);
    else passed++;
    step();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    accept_req(32'h00000077, 32'h7, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_addr, out_be, out_data, out_last} !==
          {1'b1, 1'b0, 32'h4, 4'b1000, 32'h77000000, 1'b1})
        $display("FAIL stall_hold%0d: got v=%b rdy=%b a=%h be=%b d=%h l=%b required v=1 rdy=0 a=00000004 be=1000 d=77000000 l=1",
                 i, out_valid, in_ready, out_addr, out_be, out_data, out_last);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, out_addr, out_data} !== {1'b1, 1'b1, 32'h4, 32'h77000000})
      $display("FAIL stall_release: got v=%b rdy=%b a=%h d=%h required v=1 rdy=1 a=00000004 d=77000000",
               out_valid, in_ready, out_addr, out_data);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL stall_done: out_valid got %b required 0", out_valid);
    else passed++;
    step();
  endtask

  task automatic test_range;
    out_ready = 1'b1;
    accept_req(32'hFFFFFF80, 32'h300, 2'd0, 1'b1);
    @(negedge clk);
    total++;
    if ({err_range, out_data, out_be} !== {1'b0, 32'h00000080, 4'b0001})
      $display("FAIL range_signed_ok: got er=%b d=%h be=%b required er=0 d=00000080 be=0001",
               err_range, out_data, out_be);
    else passed++;
    step();
    accept_req(32'h00000180, 32'h300, 2'd0, 1'b1);
    @(negedge clk);
    total++;
    if ({err_range, out_data, out_be} !== {RANGE_EN, 32'h00000080, 4'b0001})
      $display("FAIL range_signed_bad: got er=%b d=%h be=%b required er=%b d=00000080 be=0001",
               err_range, out_data, out_be, RANGE_EN);
    else passed++;
    step();
  endtask

  task automatic test_wrap_and_reset;
    out_ready = 1'b1;
    accept_req(32'h11223344, 32'hFFFFFFFE, 2'd2, 1'b0);
    @(negedge clk);
    total++;
    if ({out_addr, out_be, out_data, out_last} !== {32'hFFFFFFFC, 4'b1100, 32'h33440000, 1'b0})
      $display("FAIL wrap_beat1: got a=%h be=%b d=%h l=%b required a=fffffffc be=1100 d=33440000 l=0",
               out_addr, out_be, out_data, out_last);
    else passed++;
    step();
    @(negedge clk);
    total++;
    if ({out_valid, out_addr, out_be, out_data, out_last} !== {1'b1, 32'h0, 4'b0011, 32'h00001122, 1'b1})
      $display("FAIL wrap_beat2: got v=%b a=%h be=%b d=%h l=%b required v=1 a=00000000 be=0011 d=00001122 l=1",
               out_valid, out_addr, out_be, out_data, out_last);
    else passed++;
    step();
    // second split request, aborted by reset between its beats
    out_ready = 1'b0;
    accept_req(32'h11223344, 32'hFFFFFFFE, 2'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_addr, out_data, out_be, out_last, err_range} !== 70'h0)
      $display("FAIL abort_reset: got v=%b a=%h d=%h be=%b l=%b er=%b required all 0",
               out_valid, out_addr, out_data, out_be, out_last, err_range);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL abort_no_beat%0d: got v=%b rdy=%b required v=0 rdy=1", i, out_valid, in_ready);
      else passed++;
    end
    step();
  endtask

  task automatic test_rsvd_size;
    out_ready = 1'b1;
    accept_req(32'h12345678, 32'h40, 2'd3, 1'b0);
    // immediately offer an aligned word
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_addr = 32'h80; in_size = 2'd2; in_signed = 1'b0;
    @(negedge clk);
    total++;
    if ({err_size, out_valid, in_ready} !== 3'b101)
      $display("FAIL rsvd_pulse: got es=%b v=%b rdy=%b required es=1 v=0 rdy=1", err_size, out_valid, in_ready);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({err_size, out_valid, out_addr, out_data, out_be} !== {1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 4'b1111})
      $display("FAIL rsvd_next: got es=%b v=%b a=%h d=%h be=%b required es=0 v=1 a=00000080 d=cafef00d be=1111",
               err_size, out_valid, out_addr, out_data, out_be);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev;
    out_ready = 1'b1;
    prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_addr = 32'h1000 + 32'(4 * i);
      in_size = 2'd2; in_signed = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b required 1", i, in_ready);
      else passed++;
      if (i > 0) begin
        total++;
        if ({out_valid, out_data, out_addr, out_last} !== {1'b1, prev, 32'h1000 + 32'(4 * (i - 1)), 1'b1})
          $display("FAIL b2b_beat%0d: got v=%b d=%h a=%h l=%b required v=1 d=%h a=%h l=1",
                   i, out_valid, out_data, out_addr, out_last, prev, 32'h1000 + 32'(4 * (i - 1)));
        else passed++;
      end
      prev = in_data;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_data} !== {1'b1, prev})
      $display("FAIL b2b_final: got v=%b d=%h required v=1 d=%h", out_valid, out_data, prev);
    else passed++;
    step();
  endtask

  task automatic test_random;
    logic [BW-1:0] e;
    bit pend_err, accepted;
    exp_q.delete();
    pend_err = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid  = 1'b1;
        in_data   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300)) - 32'd150;
        in_addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
        in_size   = 2'($urandom_range(0, 3));
        in_signed = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      total++;
      if (err_size !== pend_err) $display("FAIL rnd_err_size c%0d: got %b required %b", cyc, err_size, pend_err);
      else passed++;
      pend_err = 1'b0;
      total++;
      if (out_valid !== (exp_q.size() != 0))
        $display("FAIL rnd_valid c%0d: got %b required %b", cyc, out_valid, exp_q.size() != 0);
      else passed++;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({out_addr, out_data, out_be, out_last, err_range} !== e)
          $display("FAIL rnd_beat c%0d: got a=%h d=%h be=%b l=%b er=%b required a=%h d=%h be=%b l=%b er=%b",
                   cyc, out_addr, out_data, out_be, out_last, err_range,
                   e[69:38], e[37:6], e[5:2], e[1], e[0]);
        else passed++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        model_push(in_data, in_addr, in_size, in_signed);
        if (in_size == 2'd3) pend_err = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({out_addr, out_data, out_be, out_last, err_range} !== e)
          $display("FAIL rnd_drain: got a=%h d=%h be=%b l=%b er=%b required a=%h d=%h be=%b l=%b er=%b",
                   out_addr, out_data, out_be, out_last, err_range,
                   e[69:38], e[37:6], e[5:2], e[1], e[0]);
        else passed++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if ({out_valid, 32'(exp_q.size())} !== 33'h0)
      $display("FAIL rnd_empty: got v=%b pending=%0d required v=0 pending=0", out_valid, exp_q.size());
    else passed++;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_aligned();
    test_half_split();
    test_backpressure();
    test_range();
    test_wrap_and_reset();
    test_rsvd_size();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
